// File: rtl/serial_receiver_pkg.sv
// Shared types for the UART receive path: one-hot receiver state and counter widths.
package serial_receiver_pkg;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BREAK = 5'b10000
  } rx_state_e;

  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

endpackage

// File: rtl/serial_receiver_fifo.sv
// Byte FIFO with show-ahead head: dout is the oldest entry whenever valid is high.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign valid      = !empty;
  assign dout       = mem_q[rd_ptr_q];
  assign data_count = cnt_q;
  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;

  always_comb begin
    cnt_d = cnt_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + CNT_ONE;
    else if (!do_wr && do_rd) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/serial_receiver.sv
// UART 8N1 receiver: 2-flop RX synchronizer, mid-bit sampling deframer, byte FIFO.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int CLK_IN = 0,
  parameter int BAUD   = 0,
  parameter int DEPTH  = 512
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   RX,
  input  logic                   rd_en,
  output logic [7:0]             dout,
  output logic                   valid,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] data_count,
  output logic                   busy,
  output logic                   framing_error,
  output logic                   overrun
);

  localparam int BIT_CNT  = (BAUD > 0) ? CLK_IN / BAUD : 0;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  if (BIT_CNT < 4 || BIT_CNT > 65535) begin : g_bad_rate
    $error("serial_receiver: CLK_IN/BAUD must be within 4..65535");
  end

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push, frame_err, ovr, fifo_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_err = 1'b0;
    ovr       = 1'b0;
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HALF_LAST) begin
          // A start bit still low at its midpoint is real; otherwise it was a glitch.
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BIT_LAST) begin
          shreg_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BIT_LAST) begin
          if (rx_s_q) begin
            if (fifo_full) ovr  = 1'b1;
            else           push = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign framing_error = frame_err && !srst;
  assign overrun       = ovr && !srst;

  fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) uart_rx_fifo (
    .clk        (clk),
    .srst       (srst),
    .wr_en      (push && !srst),
    .din        (shreg_q),
    .rd_en      (rd_en),
    .dout       (dout),
    .valid      (valid),
    .empty      (empty),
    .full       (fifo_full),
    .data_count (data_count)
  );

endmodule

// File: tb/tb_serial_receiver.sv
// Directed + randomized bench for serial_receiver with a queue-based receive model.
module tb_serial_receiver;

  localparam int CLK_IN = 16;
  localparam int BAUD   = 1;
  localparam int DEPTH  = 4;
  localparam int BITT   = CLK_IN / BAUD;
  localparam int HALF   = BITT / 2;

  logic                   clk = 1'b0;
  logic                   srst = 1'b1;
  logic                   RX = 1'b1;
  logic                   rd_en = 1'b0;
  logic [7:0]             dout;
  logic                   valid, empty, busy, framing_error, overrun;
  logic [$clog2(DEPTH):0] data_count;

  int checks = 0, errors = 0;
  int fe_cnt = 0, ov_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  logic [7:0] q[$];

  serial_receiver #(.CLK_IN(CLK_IN), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst(srst), .RX(RX), .rd_en(rd_en), .dout(dout), .valid(valid),
    .empty(empty), .data_count(data_count), .busy(busy),
    .framing_error(framing_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framing_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1)       ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    RX = v;
    tick(BITT);
  endtask

  // Model: good stop -> byte queued unless already full (overrun); bad stop -> framing error.
  // A read overlapping the stop-bit decision pops only after the full test.
  task automatic rx(input logic [7:0] b, input logic stop_v, input bit rd_mid);
    bit was_empty, was_full;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    if (!stop_v)       exp_fe++;
    else if (was_full) exp_ov++;
    else               q.push_back(b);
    if (rd_mid && !was_empty) q.delete(0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    RX = stop_v;
    if (rd_mid) begin
      // Stop-bit decision falls 10 clocks into the stop bit (2 sync + half-bit phase).
      tick(10);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(BITT - 11);
    end else begin
      tick(BITT);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (q.size() == 0) begin
      chk({tag, "_model_nonempty"}, 32'(0), 32'(1));
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, 32'(valid), 32'(1));
      chk({tag, "_dout"}, 32'(dout), 32'(e));
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
    end
  endtask

  task automatic drain_chk(input string tag);
    while (q.size() > 0) pop_chk(tag);
    chk({tag, "_empty"}, 32'(empty), 32'(1));
  endtask

  task automatic flags_chk(input string tag);
    chk({tag, "_fe"}, 32'(fe_cnt), 32'(exp_fe));
    chk({tag, "_ov"}, 32'(ov_cnt), 32'(exp_ov));
    chk({tag, "_count"}, 32'(data_count), 32'(q.size()));
  endtask

  initial begin
    int nb;
    logic [7:0] b;
    bit good, rdm;

    tick(4);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_count", 32'(data_count), 32'(0));
    chk("rst_fe", 32'(framing_error), 32'(0));
    chk("rst_ov", 32'(overrun), 32'(0));
    srst = 1'b0;
    tick(3 * BITT);

    // single byte
    rx(8'h55, 1'b1, 1'b0);
    tick(2);
    chk("b55_valid", 32'(valid), 32'(1));
    chk("b55_dout", 32'(dout), 32'h55);
    chk("b55_count", 32'(data_count), 32'(1));
    pop_chk("b55_pop");
    chk("b55_empty", 32'(empty), 32'(1));
    flags_chk("b55");

    // back-to-back frames, no idle gap
    rx(8'hA3, 1'b1, 1'b0);
    rx(8'h0F, 1'b1, 1'b0);
    tick(BITT);
    chk("b2b_count", 32'(data_count), 32'(2));
    flags_chk("b2b");
    drain_chk("b2b");

    // 3-cycle glitch
    nb = 0;
    fork
      begin RX = 1'b0; tick(3); RX = 1'b1; end
      begin repeat (3 * BITT) begin @(negedge clk); if (busy) nb++; end end
    join
    #1;
    chk("glitch_seen", 32'(nb > 0), 32'(1));
    chk("glitch_short", 32'(nb < HALF + 3), 32'(1));
    chk("glitch_idle", 32'(busy), 32'(0));
    flags_chk("glitch");

    // bad stop then held-low break
    rx(8'h3C, 1'b0, 1'b0);
    tick(40 * BITT);
    chk("break_busy", 32'(busy), 32'(1));
    chk("break_one_fe", 32'(fe_cnt), 32'(exp_fe));
    RX = 1'b1;
    tick(4);
    chk("break_release", 32'(busy), 32'(0));
    flags_chk("break");
    tick(2 * BITT);

    // overrun with full FIFO
    for (int i = 1; i <= 5; i++) begin
      rx(8'(i), 1'b1, 1'b0);
      send_bit(1'b1);
    end
    flags_chk("ovr");
    drain_chk("ovr");

    // overrun despite read in the decision cycle
    for (int i = 0; i < 4; i++) begin
      rx(8'($urandom), 1'b1, 1'b0);
      send_bit(1'b1);
    end
    rx(8'($urandom), 1'b1, 1'b1);
    send_bit(1'b1);
    flags_chk("ovr_rd");
    drain_chk("ovr_rd");

    // srst during DATA bit 4 of 0x77
    rx(8'h9A, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("pre_rst_count", 32'(data_count), 32'(1));
    b = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    RX = b[4];
    tick(5);
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    q.delete();
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_empty", 32'(empty), 32'(1));
    RX = 1'b1;
    tick(2 * BITT);
    rx(8'h12, 1'b1, 1'b0);
    tick(BITT);
    flags_chk("post_rst");
    drain_chk("post_rst");

    // randomized frames, stop errors, reads, gaps
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 9) != 0);
      rdm  = ($urandom_range(0, 3) == 0);
      rx(b, good, rdm);
      if (!good) begin
        RX = 1'b1;
        tick(BITT);
      end
      chk("rand_count", 32'(data_count), 32'(q.size()));
      for (int k = $urandom_range(0, 1); k > 0; k--)
        if (q.size() > 0) pop_chk("rand_pop");
      if ($urandom_range(0, 1) == 1) send_bit(1'b1);
    end
    tick(BITT);
    flags_chk("rand");
    drain_chk("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
